dpram_port_arbiter: RTL
=======================

Name: dpram_port_arbiter

Overview:
Two-requester arbiter that shares one port of the 32-bit dual-port RAM wrapper (1-cycle registered read latency) between the core data path (m0) and a host/loader master (m1).
- Grants combinationally, forwards the winning command to the RAM port, and routes the read data back to the requester that issued the read one cycle earlier.
- Fairness: round-robin with a bounded burst length.

Parameters:
AddrWidth, 10, word address width; matches the RAM port address.
DataWidth, 32, data width; byte-enable width is DataWidth/8.
MaxBurst, 4, max consecutive grants to one requester while the other is waiting; must be >=1, otherwise $fatal at elaboration.

Ports:
clk_i  in  1  clock; RAM port clock tied to the same net
rst_i  in  1  synchronous reset, active-high
m0_req_i  in  1  m0 access request
m0_we_i  in  1  m0 write (1) / read (0)
m0_addr_i  in  AddrWidth  m0 word address
m0_wdata_i  in  DataWidth  m0 write data
m0_be_i  in  DataWidth/8  m0 byte enables
m0_gnt_o  out  1  m0 granted this cycle (combinational)
m0_rvalid_o  out  1  m0 read data valid (registered)
m0_rdata_o  out  DataWidth  m0 read data
m1_*  same eight signals as m0_*, for requester m1
mem_addr_o  out  AddrWidth  RAM port address
mem_din_o  out  DataWidth  RAM port write data
mem_be_o  out  DataWidth/8  RAM port byte enables
mem_wren_o  out  1  RAM port write enable
mem_rden_o  out  1  RAM port read enable
mem_dout_i  in  DataWidth  RAM port read data (valid 1 cycle after mem_rden_o)

Behaviour:
- State registers:
  - owner_q: last granted requester; reset value 0 (m0).
  - burst_q: consecutive grants to owner_q; width $clog2(MaxBurst+1); reset value 0.
  - rsel_q: 2-bit one-hot read-return select; reset value 00.
- Grant selection, same cycle as the request:
  - Only one requester active: that requester wins.
  - Both active, burst_q < MaxBurst: owner_q wins.
  - Both active, burst_q == MaxBurst: the other requester wins.
  - No request: no grant.
- State update, each posedge:
  - Winner == owner_q: burst_q <= burst_q+1, saturating at MaxBurst.
  - Winner != owner_q: owner_q <= winner, burst_q <= 1.
  - No request: burst_q <= 0, owner_q held.
- Command forwarding while a grant is active:
  - mem_addr_o = winner addr.
  - mem_wren_o = winner we.
  - mem_rden_o = ~winner we.
  - mem_din_o = winner wdata.
  - mem_be_o = winner be on writes, 0 on reads.
  - Idle: all mem_* outputs 0.
- A write with be=0 is still granted and issues mem_wren_o=1 with mem_be_o=0; the RAM contents are unchanged.
- Read return:
  - rsel_q <= one-hot of the read winner, or 00 if no read this cycle.
  - mX_rvalid_o = rsel_q[X].
  - mX_rdata_o = mem_dout_i when mX_rvalid_o, else 0.
  - Latency is request-to-data 1 cycle. Back-to-back reads from alternating requesters are supported at full rate.
- Writes produce no response; gnt is the completion.
- A requester holds req and command stable until it sees gnt. Changing them before gnt is legal; only the value present in the granting cycle is used.
- Reset values: every output is 0 while rst_i is asserted. Reset mid-read drops the pending rvalid (rsel_q cleared), and no rvalid appears in the cycle after reset deasserts.
- Write and read to the same address in consecutive cycles: the read returns the newly written data; the RAM write completes before the next read.

Optional Feature:
DPRAM_ARB_PERF_EN
- Defined: adds outputs m0_gnt_cnt_o, m1_gnt_cnt_o and conflict_cnt_o, each 32 bits.
  - m0_gnt_cnt_o / m1_gnt_cnt_o increment on each grant to that requester.
  - conflict_cnt_o increments each cycle in which both requesters are active.
  - All three reset to 0 and wrap from 2^32-1 to 0.
- Undefined: these ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Single read: m0 reads addr 0x010 holding 0xDEADBEEF -> m0_gnt_o=1 in cycle 0, mem_rden_o=1, mem_addr_o=0x010; in cycle 1, m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m1_rvalid_o=0.
- Contention with MaxBurst=4: both hold req for 10 cycles -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0,m0.
- Interleaved reads: m0 reads 0x001 (0x11111111) and m1 reads 0x002 (0x22222222) continuously -> each rvalid is routed to the correct requester with the matching data; m0_rdata_o is 0 whenever m0_rvalid_o=0.
- Byte write then read: m1 writes 0xAABBCCDD with be=0100 to 0x3FF (holding 0x00000000); next cycle m1 reads 0x3FF -> 0x00BB0000.
- Reset mid-operation: m0 read granted, rst_i asserted the following cycle -> m0_rvalid_o=0 and all outputs 0; after release, m0 is granted first when both request.
- With DPRAM_ARB_PERF_EN: run the contention test for 10 cycles -> m0_gnt_cnt_o=6, m1_gnt_cnt_o=4, conflict_cnt_o=10; preload a counter to 0xFFFFFFFF, one more event -> 0.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin arbiter sharing one DPRAM port between two requesters
//
// Purpose: grants one of two requesters (m0 core, m1 host/loader) per cycle,
// forwards the winning command to the RAM port and steers the 1-cycle-late
// read data back to the requester that issued the read.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mX_req_i/we_i/addr_i/wdata_i/be_i   requester command (X = 0, 1)
//   mX_gnt_o                     combinational grant
//   mX_rvalid_o/rdata_o          read return, one cycle after the grant
//   mem_addr_o/din_o/be_o/wren_o/rden_o, mem_dout_i   RAM port
// Optional macro DPRAM_ARB_PERF_EN adds m0_gnt_cnt_o, m1_gnt_cnt_o and
// conflict_cnt_o (32-bit wrapping event counters).

module dpram_port_arbiter #(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   m0_req_i,
  input  logic                   m0_we_i,
  input  logic [AddrWidth-1:0]   m0_addr_i,
  input  logic [DataWidth-1:0]   m0_wdata_i,
  input  logic [DataWidth/8-1:0] m0_be_i,
  output logic                   m0_gnt_o,
  output logic                   m0_rvalid_o,
  output logic [DataWidth-1:0]   m0_rdata_o,
  input  logic                   m1_req_i,
  input  logic                   m1_we_i,
  input  logic [AddrWidth-1:0]   m1_addr_i,
  input  logic [DataWidth-1:0]   m1_wdata_i,
  input  logic [DataWidth/8-1:0] m1_be_i,
  output logic                   m1_gnt_o,
  output logic                   m1_rvalid_o,
  output logic [DataWidth-1:0]   m1_rdata_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_din_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic                   mem_wren_o,
  output logic                   mem_rden_o,
  input  logic [DataWidth-1:0]   mem_dout_i
`ifdef DPRAM_ARB_PERF_EN
  ,
  output logic [31:0]            m0_gnt_cnt_o,
  output logic [31:0]            m1_gnt_cnt_o,
  output logic [31:0]            conflict_cnt_o
`endif
);

  localparam int BurstWidth = $clog2(MaxBurst + 1);
  localparam logic [BurstWidth-1:0] BurstMax = BurstWidth'(MaxBurst);
  localparam logic [BurstWidth-1:0] BurstOne = BurstWidth'(1);

  generate
    if (MaxBurst < 1) begin : g_bad_max_burst
      $fatal(1, "dpram_port_arbiter: MaxBurst must be >= 1");
    end
  endgenerate

  logic                   owner_q;   // 0 = m0, 1 = m1
  logic [BurstWidth-1:0]  burst_q;
  logic [1:0]             rsel_q;

  logic                   any_req;
  logic                   both_req;
  logic                   win1;
  logic                   sel_we;
  logic [AddrWidth-1:0]   sel_addr;
  logic [DataWidth-1:0]   sel_wdata;
  logic [DataWidth/8-1:0] sel_be;

  // Reset gates the request view so every output is quiet while rst_i is high.
  always_comb begin
    any_req  = ~rst_i & (m0_req_i | m1_req_i);
    both_req = ~rst_i & m0_req_i & m1_req_i;
    if (both_req) begin
      // Owner keeps the port until its burst is used up, then hands over.
      win1 = (burst_q == BurstMax) ? ~owner_q : owner_q;
    end else begin
      win1 = m1_req_i;
    end
    sel_we    = win1 ? m1_we_i    : m0_we_i;
    sel_addr  = win1 ? m1_addr_i  : m0_addr_i;
    sel_wdata = win1 ? m1_wdata_i : m0_wdata_i;
    sel_be    = win1 ? m1_be_i    : m0_be_i;
  end

  assign m0_gnt_o   = any_req & ~win1;
  assign m1_gnt_o   = any_req & win1;
  assign mem_addr_o = any_req ? sel_addr : '0;
  assign mem_din_o  = any_req ? sel_wdata : '0;
  assign mem_be_o   = (any_req & sel_we) ? sel_be : '0;
  assign mem_wren_o = any_req & sel_we;
  assign mem_rden_o = any_req & ~sel_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= 1'b0;
      burst_q <= '0;
      rsel_q  <= 2'b00;
    end else begin
      rsel_q <= {m1_gnt_o & ~m1_we_i, m0_gnt_o & ~m0_we_i};
      if (!any_req) begin
        burst_q <= '0;
      end else if (win1 == owner_q) begin
        if (burst_q != BurstMax) begin
          burst_q <= burst_q + BurstOne;
        end
      end else begin
        owner_q <= win1;
        burst_q <= BurstOne;
      end
    end
  end

  // A pending return is dropped as soon as reset is seen, not one cycle later.
  assign m0_rvalid_o = rsel_q[0] & ~rst_i;
  assign m1_rvalid_o = rsel_q[1] & ~rst_i;
  assign m0_rdata_o  = m0_rvalid_o ? mem_dout_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_dout_i : '0;

`ifdef DPRAM_ARB_PERF_EN
  logic [31:0] m0_gnt_cnt_q;
  logic [31:0] m1_gnt_cnt_q;
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m0_gnt_cnt_q   <= '0;
      m1_gnt_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (m0_gnt_o) m0_gnt_cnt_q <= m0_gnt_cnt_q + 32'd1;
      if (m1_gnt_o) m1_gnt_cnt_q <= m1_gnt_cnt_q + 32'd1;
      if (both_req) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign m0_gnt_cnt_o   = m0_gnt_cnt_q;
  assign m1_gnt_cnt_o   = m1_gnt_cnt_q;
  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
